// File: rtl/spike_rate_monitor.sv
// Threshold-with-hysteresis spike detector on an 8-bit membrane stream, with
// inter-spike interval measurement and a windowed spike-rate valid/ack output.
module spike_rate_monitor #(
  parameter int unsigned WINDOW_LOG2 = 8,
  parameter logic [7:0]  THRESH      = 8'd200,
  parameter logic [7:0]  HYST        = 8'd20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] membrane,
  output logic       spike_out,
  output logic [7:0] isi,
  output logic       isi_valid,
  output logic [7:0] rate,
  output logic       rate_valid,
  input  logic       rate_ack,
  output logic       overrun
);

  localparam int unsigned CW = 8;
  localparam logic [0:0] ARMED = 1'b0;
  localparam logic [0:0] FIRED = 1'b1;
  localparam logic [CW-1:0] REARM = THRESH - HYST;
  localparam logic [CW-1:0] SAT   = '1;
  localparam logic [WINDOW_LOG2-1:0] WLAST = '1;

  logic [0:0]             state, state_nxt;
  logic                   spike_nxt;
  logic [CW-1:0]          isi_nxt;
  logic                   isi_valid_nxt;
  logic                   seen, seen_nxt;
  logic [CW-1:0]          icnt, icnt_nxt;
  logic [WINDOW_LOG2-1:0] wcnt, wcnt_nxt;
  logic [CW-1:0]          scnt, scnt_nxt;
  logic [CW-1:0]          rate_nxt;
  logic                   rate_valid_nxt;
  logic                   overrun_nxt;

  logic          spike_c;
  logic          close_c;
  logic [CW-1:0] icnt_inc_c;
  logic [CW-1:0] scnt_sum_c;

  // Next-state and next-output logic; everything holds unless en samples
  always_comb begin
    state_nxt      = state;
    spike_nxt      = 1'b0;
    isi_nxt        = isi;
    isi_valid_nxt  = isi_valid;
    seen_nxt       = seen;
    icnt_nxt       = icnt;
    wcnt_nxt       = wcnt;
    scnt_nxt       = scnt;
    rate_nxt       = rate;
    rate_valid_nxt = rate_valid;
    overrun_nxt    = overrun;

    spike_c    = (state == ARMED) && (membrane >= THRESH);
    close_c    = (wcnt == WLAST);
    icnt_inc_c = (icnt == SAT) ? SAT : icnt + CW'(1);
    scnt_sum_c = (spike_c && scnt != SAT) ? scnt + CW'(1) : scnt;

    if (en) begin
      case (state)
        ARMED:   if (membrane >= THRESH) state_nxt = FIRED;
        FIRED:   if (membrane < REARM)   state_nxt = ARMED;
        default: state_nxt = ARMED;
      endcase

      spike_nxt = spike_c;

      // The first spike only starts ISI tracking; later spikes report it
      if (spike_c) begin
        if (seen) begin
          isi_nxt       = icnt_inc_c;
          isi_valid_nxt = 1'b1;
        end
        seen_nxt = 1'b1;
        icnt_nxt = '0;
      end else begin
        icnt_nxt = icnt_inc_c;
      end

      if (close_c) begin
        rate_nxt       = scnt_sum_c;
        scnt_nxt       = '0;
        wcnt_nxt       = '0;
        rate_valid_nxt = 1'b1;
        if (rate_valid && !rate_ack) overrun_nxt = 1'b1;
        else if (rate_valid && rate_ack) overrun_nxt = 1'b0;
      end else begin
        scnt_nxt = scnt_sum_c;
        wcnt_nxt = wcnt + WINDOW_LOG2'(1);
        if (rate_valid && rate_ack) begin
          rate_valid_nxt = 1'b0;
          overrun_nxt    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARMED;
      spike_out  <= 1'b0;
      isi        <= '0;
      isi_valid  <= 1'b0;
      seen       <= 1'b0;
      icnt       <= '0;
      wcnt       <= '0;
      scnt       <= '0;
      rate       <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      spike_out  <= spike_nxt;
      isi        <= isi_nxt;
      isi_valid  <= isi_valid_nxt;
      seen       <= seen_nxt;
      icnt       <= icnt_nxt;
      wcnt       <= wcnt_nxt;
      scnt       <= scnt_nxt;
      rate       <= rate_nxt;
      rate_valid <= rate_valid_nxt;
      overrun    <= overrun_nxt;
    end
  end

endmodule
